// File: rtl/pcseq_pkg.sv
// ============================================================================
// Module      : pcseq_pkg
// Description : Shared types for the program-counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcseq_pkg;

    localparam int unsigned c_OP_W = 3;

    // Codes 6 and 7 are left unnamed; the sequencer treats them as OP_SEQ.
    typedef enum logic [c_OP_W-1:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRZ  = 3'd2,
        OP_BRC  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } pc_op_t;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module      : ras_stack
// Description : Return-address stack built as a ring buffer with an occupancy
//               count. PCSEQ_CIRC_STACK_EN lets a push while full overwrite
//               the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_W-1:0]              din,
    output logic [PC_W-1:0]              top,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned c_SP_W  = $clog2(DEPTH+1);
    localparam int unsigned c_PTR_W = $clog2(DEPTH);
`ifdef PCSEQ_CIRC_STACK_EN
    localparam bit c_CIRC = 1'b1;
`else
    localparam bit c_CIRC = 1'b0;
`endif

    logic [PC_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [c_PTR_W-1:0] w_wr_ptr_inc;
    logic [c_SP_W-1:0]  r_sp;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_sp == c_SP_W'(DEPTH));
    assign empty = (r_sp == '0);
    assign sp    = r_sp;

    // Push wins if both are requested; the sequencer never asks for both.
    assign w_do_push = push && (!full || c_CIRC);
    assign w_do_pop  = pop && !push && !empty;

    assign w_wr_ptr_inc = (r_wr_ptr == c_PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
    assign w_rd_ptr     = (r_wr_ptr == '0) ? c_PTR_W'(DEPTH-1) : r_wr_ptr - c_PTR_W'(1);
    assign top          = r_mem[w_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp     <= '0;
            r_wr_ptr <= '0;
        end else if (w_do_push) begin
            r_wr_ptr <= w_wr_ptr_inc;
            if (!full) begin
                r_sp <= r_sp + c_SP_W'(1);
            end
        end else if (w_do_pop) begin
            r_wr_ptr <= w_rd_ptr;
            r_sp     <= r_sp - c_SP_W'(1);
        end
    end

    // Contents need no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : PC register, next-PC mux, branch adder and return stack with
//               sticky overflow/underflow flags. Build macro
//               PCSEQ_CIRC_STACK_EN makes the return stack circular.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int unsigned PC_W     = 12,
    parameter int unsigned OFF_W    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [2:0]                   op,
    input  logic [PC_W-1:0]              target,
    input  logic [OFF_W-1:0]             offset,
    input  logic                         z_flag,
    input  logic                         c_flag,
    output logic [PC_W-1:0]              pc,
    output logic                         taken,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         ovf_err,
    output logic                         unf_err
);

    import pcseq_pkg::*;

`ifdef PCSEQ_CIRC_STACK_EN
    localparam bit c_CIRC = 1'b1;
`else
    localparam bit c_CIRC = 1'b0;
`endif

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_br_pc;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_top;
    logic            w_full;
    logic            w_empty;
    logic            w_call_req;
    logic            w_ret_req;
    logic            w_ovf_set;
    logic            w_unf_set;
    logic            w_taken;
    logic            r_ovf;
    logic            r_unf;

    assign w_inc     = r_pc + PC_W'(1);
    assign w_off_ext = PC_W'($signed(offset));
    assign w_br_pc   = w_inc + w_off_ext;

    always_comb begin
        w_next_pc  = w_inc;
        w_taken    = 1'b0;
        w_call_req = 1'b0;
        w_ret_req  = 1'b0;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        case (pc_op_t'(op))
            OP_JMP: begin
                w_next_pc = target;
                w_taken   = 1'b1;
            end
            OP_BRZ: begin
                if (z_flag) begin
                    w_next_pc = w_br_pc;
                    w_taken   = 1'b1;
                end
            end
            OP_BRC: begin
                if (c_flag) begin
                    w_next_pc = w_br_pc;
                    w_taken   = 1'b1;
                end
            end
            OP_CALL: begin
                if (!w_full || c_CIRC) begin
                    w_call_req = 1'b1;
                    w_next_pc  = target;
                    w_taken    = 1'b1;
                end else begin
                    w_ovf_set  = 1'b1;
                end
            end
            OP_RET: begin
                if (!w_empty) begin
                    w_ret_req = 1'b1;
                    w_next_pc = w_top;
                    w_taken   = 1'b1;
                end else begin
                    w_unf_set = 1'b1;
                end
            end
            default: begin
                w_next_pc = w_inc;
            end
        endcase
    end

    ras_stack #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (w_call_req && !stall),
        .pop   (w_ret_req && !stall),
        .din   (w_inc),
        .top   (w_top),
        .sp    (sp),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= PC_W'(RESET_PC);
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!stall) begin
            r_pc  <= w_next_pc;
            r_ovf <= r_ovf | w_ovf_set;
            r_unf <= r_unf | w_unf_set;
        end
    end

    assign pc          = r_pc;
    assign taken       = w_taken;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign ovf_err     = r_ovf;
    assign unf_err     = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed, table-driven bench for pc_sequencer (default params).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  op;
    logic [11:0] target;
    logic [7:0]  offset;
    logic        z_flag;
    logic        c_flag;
    logic [11:0] pc;
    logic        taken;
    logic [3:0]  sp;
    logic        stack_full;
    logic        stack_empty;
    logic        ovf_err;
    logic        unf_err;

    int n_total = 0;
    int n_bad   = 0;

`ifdef PCSEQ_CIRC_STACK_EN
    localparam bit c_CIRC = 1'b1;
`else
    localparam bit c_CIRC = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [11:0] target;
        logic [7:0]  offset;
        logic        z;
        logic        c;
        logic        exp_taken;
        logic [11:0] exp_pc;
    } vec_t;

    vec_t vecs [14];

    pc_sequencer #(
        .PC_W     (12),
        .OFF_W    (8),
        .DEPTH    (8),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .op          (op),
        .target      (target),
        .offset      (offset),
        .z_flag      (z_flag),
        .c_flag      (c_flag),
        .pc          (pc),
        .taken       (taken),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [11:0] t,
                         input logic [7:0] off, input logic z, input logic c);
        op     = o;
        target = t;
        offset = off;
        z_flag = z;
        c_flag = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [11:0] t);
        drive(o, t, 8'h00, 1'b0, 1'b0);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        do_op(3'd0, 12'h000);
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] pc_m;
        logic [11:0] ret_q [$];
        logic [11:0] tgt;
        logic [11:0] exp_ret;

        vecs[0]  = '{3'd1, 12'h010, 8'h00, 1'b0, 1'b0, 1'b1, 12'h010};
        vecs[1]  = '{3'd2, 12'h000, 8'hFC, 1'b1, 1'b0, 1'b1, 12'h00D};
        vecs[2]  = '{3'd1, 12'h010, 8'h00, 1'b0, 1'b0, 1'b1, 12'h010};
        vecs[3]  = '{3'd3, 12'h000, 8'h10, 1'b1, 1'b0, 1'b0, 12'h011};
        vecs[4]  = '{3'd1, 12'h010, 8'h00, 1'b0, 1'b0, 1'b1, 12'h010};
        vecs[5]  = '{3'd2, 12'h000, 8'h7F, 1'b1, 1'b0, 1'b1, 12'h090};
        vecs[6]  = '{3'd2, 12'h000, 8'h7F, 1'b0, 1'b1, 1'b0, 12'h091};
        vecs[7]  = '{3'd3, 12'h000, 8'h80, 1'b0, 1'b1, 1'b1, 12'h012};
        vecs[8]  = '{3'd1, 12'hFFE, 8'h00, 1'b0, 1'b0, 1'b1, 12'hFFE};
        vecs[9]  = '{3'd2, 12'h000, 8'h05, 1'b1, 1'b0, 1'b1, 12'h004};
        vecs[10] = '{3'd1, 12'hFFF, 8'h00, 1'b0, 1'b0, 1'b1, 12'hFFF};
        vecs[11] = '{3'd0, 12'h555, 8'h00, 1'b1, 1'b1, 1'b0, 12'h000};
        vecs[12] = '{3'd6, 12'h555, 8'h00, 1'b1, 1'b1, 1'b0, 12'h001};
        vecs[13] = '{3'd7, 12'h555, 8'h00, 1'b1, 1'b1, 1'b0, 12'h002};

        stall = 1'b0;
        drive(3'd0, 12'h000, 8'h00, 1'b0, 1'b0);

        // Reset, then three SEQ
        do_reset();
        chk("reset_pc", int'(pc), 0);
        chk("reset_sp", int'(sp), 0);
        chk("reset_empty", int'(stack_empty), 1);
        chk("reset_full", int'(stack_full), 0);
        chk("reset_ovf", int'(ovf_err), 0);
        chk("reset_unf", int'(unf_err), 0);
        for (int i = 1; i <= 3; i++) begin
            do_op(3'd0, 12'h000);
            chk("seq_pc", int'(pc), i);
        end

        // Branch / jump / wrap table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].target, vecs[i].offset, vecs[i].z, vecs[i].c);
            #1;
            chk($sformatf("vec%0d_taken", i), int'(taken), int'(vecs[i].exp_taken));
            step();
            chk($sformatf("vec%0d_pc", i), int'(pc), int'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_sp", i), int'(sp), 0);
        end

        // Nested calls and returns
        do_op(3'd1, 12'h005);
        do_op(3'd4, 12'h100);
        chk("call1_pc", int'(pc), 12'h100);
        chk("call1_sp", int'(sp), 1);
        do_op(3'd4, 12'h200);
        chk("call2_pc", int'(pc), 12'h200);
        chk("call2_sp", int'(sp), 2);
        drive(3'd5, 12'h000, 8'h00, 1'b0, 1'b0);
        #1;
        chk("ret1_taken", int'(taken), 1);
        step();
        chk("ret1_pc", int'(pc), 12'h101);
        do_op(3'd5, 12'h000);
        chk("ret2_pc", int'(pc), 12'h006);
        chk("ret2_sp", int'(sp), 0);

        // Nine calls into an 8-deep stack, then eight returns
        do_reset();
        pc_m = 12'h000;
        for (int k = 0; k < 9; k++) begin
            tgt     = 12'h100 + 12'(k * 16);
            exp_ret = pc_m + 12'h001;
            drive(3'd4, tgt, 8'h00, 1'b0, 1'b0);
            #1;
            if (ret_q.size() < 8) begin
                ret_q.push_back(exp_ret);
                pc_m = tgt;
            end else if (c_CIRC) begin
                void'(ret_q.pop_front());
                ret_q.push_back(exp_ret);
                pc_m = tgt;
            end else begin
                pc_m = exp_ret;
            end
            if (k == 8) chk("call9_taken", int'(taken), c_CIRC ? 1 : 0);
            step();
            chk($sformatf("callk%0d_pc", k), int'(pc), int'(pc_m));
            chk($sformatf("callk%0d_sp", k), int'(sp), (k < 8) ? k + 1 : 8);
        end
        chk("ovf_err", int'(ovf_err), c_CIRC ? 0 : 1);
        chk("ovf_full", int'(stack_full), 1);
        for (int k = 0; k < 8; k++) begin
            exp_ret = ret_q.pop_back();
            do_op(3'd5, 12'h000);
            chk($sformatf("retk%0d_pc", k), int'(pc), int'(exp_ret));
        end
        chk("unwound_sp", int'(sp), 0);
        chk("unwound_empty", int'(stack_empty), 1);

        // Underflow, stickiness, stall
        do_op(3'd1, 12'h020);
        drive(3'd5, 12'h000, 8'h00, 1'b0, 1'b0);
        #1;
        chk("unf_taken", int'(taken), 0);
        step();
        chk("unf_pc", int'(pc), 12'h021);
        chk("unf_err", int'(unf_err), 1);
        do_op(3'd0, 12'h000);
        do_op(3'd1, 12'h040);
        chk("unf_sticky", int'(unf_err), 1);
        chk("ovf_sticky", int'(ovf_err), c_CIRC ? 0 : 1);
        chk("jmp_040", int'(pc), 12'h040);
        stall = 1'b1;
        drive(3'd1, 12'h300, 8'h00, 1'b0, 1'b0);
        #1;
        chk("stall_taken", int'(taken), 1);
        step();
        chk("stall_pc", int'(pc), 12'h040);
        do_op(3'd4, 12'h123);
        chk("stall_call_sp", int'(sp), 0);
        chk("stall_call_pc", int'(pc), 12'h040);
        stall = 1'b0;
        do_op(3'd1, 12'h300);
        chk("release_pc", int'(pc), 12'h300);
        do_reset();
        chk("rst_clr_unf", int'(unf_err), 0);
        chk("rst_clr_ovf", int'(ovf_err), 0);

        // Reset while a CALL is presented with a populated stack
        do_op(3'd4, 12'h080);
        do_op(3'd4, 12'h090);
        do_op(3'd4, 12'h200);
        chk("mid_sp", int'(sp), 3);
        chk("mid_pc", int'(pc), 12'h200);
        rst = 1'b1;
        do_op(3'd4, 12'h333);
        rst = 1'b0;
        chk("rstcall_pc", int'(pc), 0);
        chk("rstcall_sp", int'(sp), 0);
        do_op(3'd5, 12'h000);
        chk("rstcall_ret_pc", int'(pc), 1);
        chk("rstcall_unf", int'(unf_err), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
